// File: rtl/misao_pc_unit.sv
// misao_pc_unit: program counter and control-flow unit for the MISA-O core, with a return-address stack.
// Interrupt entry and RETI exist only when MISAO_PCU_IRQ_EN is defined; otherwise WFI halts until reset.
//
// state | meaning
// RUN   | accepting control ops
// FLUSH | bubble cycles after a taken redirect, down-counter to zero
// HALT  | stopped after WFI
module misao_pc_unit #(
    parameter int unsigned       ADDR_W       = 15,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter int unsigned       FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(4)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ctl_valid,
    output logic                           ctl_ready,
    input  logic [2:0]                     ctl_op,
    input  logic [3:0]                     ctl_imm,
    input  logic                           acc_zero,
    input  logic                           carry,
    input  logic [ADDR_W-1:0]              ra0,
    input  logic                           irq,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              ra1,
    output logic                           redirect,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_underflow,
    output logic                           halted
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RAS_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BEQZ = 3'b001,
        OP_BC   = 3'b010,
        OP_JAL  = 3'b011,
        OP_JMP  = 3'b100,
        OP_RET  = 3'b101,
        OP_WFI  = 3'b110,
        OP_RETI = 3'b111
    } op_t;

    state_t            state, state_nxt;
    logic [FL_W-1:0]   flush_cnt, flush_cnt_nxt;
    logic [ADDR_W-1:0] pc_nxt, ra1_nxt;
    logic              redirect_nxt, underflow_nxt;
    logic              accept, taken, push, pop, irq_take;

    logic [ADDR_W-1:0] seq_pc, br_pc;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wp, wp_inc, top_idx;
    logic [ADDR_W-1:0] ras_top;

    assign ctl_ready = (state == ST_RUN);
    assign halted    = (state == ST_HALT);
    assign accept    = ctl_valid && ctl_ready;

    assign seq_pc = pc + ADDR_W'(1);
    assign br_pc  = seq_pc + {{(ADDR_W-4){ctl_imm[3]}}, ctl_imm};

    // wp is the next write slot; the top of stack sits just below it, circularly.
    assign wp_inc  = (wp == PTR_LAST) ? '0 : wp + PTR_W'(1);
    assign top_idx = (wp == '0) ? PTR_LAST : wp - PTR_W'(1);
    assign ras_top = ras_mem[top_idx];

`ifdef MISAO_PCU_IRQ_EN
    logic [ADDR_W-1:0] epc, epc_nxt;
    logic              ie, ie_nxt;

    assign irq_take = irq && ie &&
                      (((state == ST_RUN) && !ctl_valid) || (state == ST_HALT));
`else
    logic unused_irq;

    assign irq_take   = 1'b0;
    assign unused_irq = irq ^ (^IRQ_VEC);
`endif

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pc_nxt        = pc;
        ra1_nxt       = ra1;
        redirect_nxt  = 1'b0;
        underflow_nxt = ras_underflow;
        taken         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
`ifdef MISAO_PCU_IRQ_EN
        epc_nxt       = epc;
        ie_nxt        = ie;
`endif

        case (state)
            ST_RUN: begin
                if (accept) begin
                    case (ctl_op)
                        OP_SEQ: pc_nxt = seq_pc;
                        OP_BEQZ: begin
                            pc_nxt = acc_zero ? br_pc : seq_pc;
                            taken  = acc_zero;
                        end
                        OP_BC: begin
                            pc_nxt = carry ? br_pc : seq_pc;
                            taken  = carry;
                        end
                        OP_JAL: begin
                            pc_nxt  = ra0;
                            ra1_nxt = seq_pc;
                            push    = 1'b1;
                            taken   = 1'b1;
                        end
                        OP_JMP: begin
                            pc_nxt = ra0;
                            taken  = 1'b1;
                        end
                        OP_RET: begin
                            taken = 1'b1;
                            if (ras_count != '0) begin
                                pc_nxt = ras_top;
                                pop    = 1'b1;
                            end else begin
                                pc_nxt        = ra1;
                                underflow_nxt = 1'b1;
                            end
                        end
                        OP_WFI: begin
                            pc_nxt    = seq_pc;
                            state_nxt = ST_HALT;
                        end
                        default: begin
`ifdef MISAO_PCU_IRQ_EN
                            pc_nxt = epc;
                            ie_nxt = 1'b1;
                            taken  = 1'b1;
`else
                            pc_nxt = seq_pc;
`endif
                        end
                    endcase
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - FL_W'(1);
                end
            end
            ST_HALT: ;
            default: state_nxt = ST_RUN;
        endcase

        // irq_take is never set while an op is accepted, so it cannot clash with the op decode.
        if (irq_take) begin
            pc_nxt = IRQ_VEC;
            taken  = 1'b1;
`ifdef MISAO_PCU_IRQ_EN
            epc_nxt = pc;
            ie_nxt  = 1'b0;
`endif
        end

        if (taken) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_LAST;
            redirect_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_RUN;
            flush_cnt     <= '0;
            pc            <= RESET_PC;
            ra1           <= '0;
            redirect      <= 1'b0;
            ras_underflow <= 1'b0;
            ras_count     <= '0;
            wp            <= '0;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            pc            <= pc_nxt;
            ra1           <= ra1_nxt;
            redirect      <= redirect_nxt;
            ras_underflow <= underflow_nxt;
            if (push) begin
                wp <= wp_inc;
                if (ras_count != RAS_FULL) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (pop) begin
                wp        <= top_idx;
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

`ifdef MISAO_PCU_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc <= '0;
            ie  <= 1'b1;
        end else begin
            epc <= epc_nxt;
            ie  <= ie_nxt;
        end
    end
`endif

    // Stack storage needs no reset: ras_count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wp] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_misao_pc_unit.sv
// Directed self-checking bench for misao_pc_unit with default parameters.
// Define MISAO_PCU_IRQ_EN on both files to exercise the interrupt path.
module tb_misao_pc_unit;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQZ = 3'b001;
    localparam logic [2:0] OP_BC   = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_WFI  = 3'b110;
    localparam logic [2:0] OP_RETI = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctl_valid = 1'b0;
    logic        ctl_ready;
    logic [2:0]  ctl_op = 3'b000;
    logic [3:0]  ctl_imm = 4'h0;
    logic        acc_zero = 1'b0;
    logic        carry = 1'b0;
    logic [14:0] ra0 = '0;
    logic        irq = 1'b0;
    logic [14:0] pc;
    logic [14:0] ra1;
    logic        redirect;
    logic [2:0]  ras_count;
    logic        ras_underflow;
    logic        halted;

    int checks = 0;
    int errors = 0;

    misao_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_valid    (ctl_valid),
        .ctl_ready    (ctl_ready),
        .ctl_op       (ctl_op),
        .ctl_imm      (ctl_imm),
        .acc_zero     (acc_zero),
        .carry        (carry),
        .ra0          (ra0),
        .irq          (irq),
        .pc           (pc),
        .ra1          (ra1),
        .redirect     (redirect),
        .ras_count    (ras_count),
        .ras_underflow(ras_underflow),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Present one op at a negedge once the unit is ready; returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [3:0] imm);
        int n = 0;
        @(negedge clk);
        while (!ctl_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ctl_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ctl_ready=%b, required 1 within 50 cycles", ctl_ready);
        end
        ctl_valid = 1'b1;
        ctl_op    = op;
        ctl_imm   = imm;
        @(posedge clk);
        #1;
        ctl_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (pc !== 15'h0) begin errors++; $display("FAIL reset_pc: got %h, required 0000", pc); end
        checks++; if (ra1 !== 15'h0) begin errors++; $display("FAIL reset_ra1: got %h, required 0000", ra1); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", ras_count); end
        checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b, required 0", ras_underflow); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b, required 0", redirect); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, required 0", halted); end
        checks++; if (ctl_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ctl_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_branch();
        ra0 = 15'h0004;
        send(OP_JMP, 4'h0);
        acc_zero = 1'b1;
        send(OP_BEQZ, 4'h2);
        checks++; if (pc !== 15'h0007) begin errors++; $display("FAIL beqz_taken_pc: got %h, required 0007", pc); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beqz_redirect: got %b, required 1", redirect); end
        checks++; if (ctl_ready !== 1'b0) begin errors++; $display("FAIL beqz_flush_ready: got %b, required 0", ctl_ready); end
        @(posedge clk);
        #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL redirect_one_cycle: got %b, required 0", redirect); end
        checks++; if (ctl_ready !== 1'b1) begin errors++; $display("FAIL flush_end_ready: got %b, required 1", ctl_ready); end
        send(OP_SEQ, 4'h0);
        acc_zero = 1'b0;
        send(OP_BEQZ, 4'h2);
        checks++; if (pc !== 15'h0009) begin errors++; $display("FAIL beqz_not_taken_pc: got %h, required 0009", pc); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL beqz_nt_redirect: got %b, required 0", redirect); end
        checks++; if (ctl_ready !== 1'b1) begin errors++; $display("FAIL beqz_nt_ready: got %b, required 1", ctl_ready); end
    endtask

    task automatic test_wrap();
        ra0 = 15'h0002;
        send(OP_JMP, 4'h0);
        carry = 1'b1;
        send(OP_BC, 4'hC);
        carry = 1'b0;
        checks++; if (pc !== 15'h7FFF) begin errors++; $display("FAIL bc_neg_wrap_pc: got %h, required 7fff", pc); end
        send(OP_SEQ, 4'h0);
        checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL seq_wrap_pc: got %h, required 0000", pc); end
        send(OP_BC, 4'h3);
        checks++; if (pc !== 15'h0001) begin errors++; $display("FAIL bc_not_taken_pc: got %h, required 0001", pc); end
    endtask

    task automatic test_jal_ret();
        ra0 = 15'h0022;
        send(OP_JMP, 4'h0);
        ra0 = 15'h0028;
        send(OP_JAL, 4'h0);
        checks++; if (pc !== 15'h0028) begin errors++; $display("FAIL jal_pc: got %h, required 0028", pc); end
        checks++; if (ra1 !== 15'h0023) begin errors++; $display("FAIL jal_ra1: got %h, required 0023", ra1); end
        checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL jal_count: got %0d, required 1", ras_count); end
        ra0 = 15'h0050;
        send(OP_JMP, 4'h0);
        checks++; if (ra1 !== 15'h0023 || ras_count !== 3'd1) begin errors++; $display("FAIL jmp_keeps_link: ra1=%h count=%0d, required 0023/1", ra1, ras_count); end
        send(OP_RET, 4'h0);
        checks++; if (pc !== 15'h0023) begin errors++; $display("FAIL ret_pc: got %h, required 0023", pc); end
        checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL ret_count: got %0d, required 0", ras_count); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL ret_redirect: got %b, required 1", redirect); end
    endtask

    task automatic test_ras_overflow();
        logic [14:0] exp_ret [5];
        exp_ret[0] = 15'h0051;
        exp_ret[1] = 15'h0041;
        exp_ret[2] = 15'h0031;
        exp_ret[3] = 15'h0021;
        exp_ret[4] = 15'h0051;
        ra0 = 15'h0010;
        send(OP_JMP, 4'h0);
        for (int i = 0; i < 5; i++) begin
            ra0 = 15'(16 * (i + 2));
            send(OP_JAL, 4'h0);
        end
        checks++; if (ras_count !== 3'd4) begin errors++; $display("FAIL ras_full_count: got %0d, required 4", ras_count); end
        checks++; if (ra1 !== 15'h0051) begin errors++; $display("FAIL ras_ra1: got %h, required 0051", ra1); end
        for (int i = 0; i < 5; i++) begin
            send(OP_RET, 4'h0);
            checks++;
            if (pc !== exp_ret[i]) begin errors++; $display("FAIL ras_ret_pc[%0d]: got %h, required %h", i, pc, exp_ret[i]); end
            checks++;
            if (ras_count !== 3'(i < 4 ? 3 - i : 0)) begin errors++; $display("FAIL ras_ret_count[%0d]: got %0d, required %0d", i, ras_count, (i < 4 ? 3 - i : 0)); end
            checks++;
            if (ras_underflow !== (i == 4)) begin errors++; $display("FAIL ras_underflow[%0d]: got %b, required %b", i, ras_underflow, (i == 4)); end
        end
        send(OP_SEQ, 4'h0);
        checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b, required 1", ras_underflow); end
    endtask

    task automatic test_wfi();
        ra0 = 15'h0010;
        send(OP_JMP, 4'h0);
        send(OP_WFI, 4'h0);
        checks++; if (pc !== 15'h0011) begin errors++; $display("FAIL wfi_pc: got %h, required 0011", pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wfi_halted: got %b, required 1", halted); end
        checks++; if (ctl_ready !== 1'b0) begin errors++; $display("FAIL wfi_ready: got %b, required 0", ctl_ready); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL wfi_redirect: got %b, required 0", redirect); end
`ifdef MISAO_PCU_IRQ_EN
        @(negedge clk);
        irq = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (pc !== 15'h0004) begin errors++; $display("FAIL irq_vec_pc: got %h, required 0004", pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL irq_halted: got %b, required 0", halted); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL irq_redirect: got %b, required 1", redirect); end
        send(OP_SEQ, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pc !== 15'h0005) begin errors++; $display("FAIL irq_masked_pc: got %h, required 0005", pc); end
        irq = 1'b0;
        send(OP_RETI, 4'h0);
        checks++; if (pc !== 15'h0011) begin errors++; $display("FAIL reti_pc: got %h, required 0011", pc); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL reti_redirect: got %b, required 1", redirect); end
`else
        @(negedge clk);
        irq = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (halted !== 1'b1 || pc !== 15'h0011) begin
                errors++;
                $display("FAIL wfi_stays_halted[%0d]: halted=%b pc=%h, required 1/0011", i, halted, pc);
            end
        end
        irq = 1'b0;
`endif
    endtask

    task automatic test_reset_in_flush();
        pulse_reset();
        ra0 = 15'h0028;
        send(OP_JMP, 4'h0);
        checks++; if (pc !== 15'h0028 || redirect !== 1'b1) begin errors++; $display("FAIL jmp_before_reset: pc=%h redirect=%b, required 0028/1", pc, redirect); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (pc !== 15'h0000) begin errors++; $display("FAIL async_reset_pc: got %h, required 0000", pc); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL async_reset_redirect: got %b, required 0", redirect); end
        checks++; if (ctl_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b, required 1", ctl_ready); end
        @(negedge clk);
        rst = 1'b1;
        send(OP_SEQ, 4'h0);
        checks++; if (pc !== 15'h0001) begin errors++; $display("FAIL post_reset_seq_pc: got %h, required 0001", pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_branch();
        test_wrap();
        test_jal_ret();
        test_ras_overflow();
        test_wfi();
        test_reset_in_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
